// File: rtl/crc_gen_param.sv
// rtl/crc_gen_param.sv - parameterised serial Galois CRC generator, LSB-first serial CRC emission
// Message bits shift in while active=1; the CRC streams out for CRC_W cycles after active falls.
module crc_gen_param #(
    parameter int               CRC_W     = 8,
    parameter logic [CRC_W-1:0] TAPS      = 8'hC4,
    parameter logic [CRC_W-1:0] SEED      = 8'hD8,
    parameter logic [CRC_W-1:0] FINAL_XOR = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic data,
    input  logic active,
    output logic ready,
    output logic crc_valid,
    output logic crc_out
);

    localparam int               CNT_W    = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CRC_W-1:0] lfsr, lfsr_nxt, lfsr_step;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             valid_nxt, out_nxt;
    logic             fb;

    always_comb begin
        fb        = data ^ lfsr[0];
        lfsr_step = (lfsr >> 1) ^ (fb ? TAPS : '0);
    end

    assign ready = (state != OUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            cnt       <= '0;
            crc_valid <= 1'b0;
            crc_out   <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            cnt       <= cnt_nxt;
            crc_valid <= valid_nxt;
            crc_out   <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        cnt_nxt   = cnt;
        valid_nxt = crc_valid;
        out_nxt   = crc_out;
        if (clr) begin
            state_nxt = IDLE;
            lfsr_nxt  = SEED;
            cnt_nxt   = '0;
            valid_nxt = 1'b0;
            out_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_nxt = 1'b0;
                    out_nxt   = 1'b0;
                    if (active) begin
                        lfsr_nxt  = lfsr_step;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (active) begin
                        lfsr_nxt = lfsr_step;
                    end else begin
                        // Falling active: bit 0 of the CRC goes out on this same edge
                        out_nxt   = lfsr[0] ^ FINAL_XOR[0];
                        valid_nxt = 1'b1;
                        lfsr_nxt  = lfsr >> 1;
                        cnt_nxt   = ONE_CNT;
                        state_nxt = OUT;
                    end
                end
                OUT: begin
                    out_nxt   = lfsr[0] ^ FINAL_XOR[cnt];
                    valid_nxt = 1'b1;
                    if (cnt == LAST_CNT) begin
                        lfsr_nxt  = SEED;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        lfsr_nxt = lfsr >> 1;
                        cnt_nxt  = cnt + ONE_CNT;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    lfsr_nxt  = SEED;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b0;
                    out_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule
